// File: rtl/gb_bus_ctrl.sv
// Game Boy cartridge bus controller.
// Synchronizes the raw cartridge strobes and address, turns cartridge reads
// into single-cycle memory read requests (driving the answer back onto the
// pad), and turns cartridge writes into single-cycle memory write strobes.
module gb_bus_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] gb_addr,
    input  logic              gb_rd_n,
    input  logic              gb_wr_n,
    input  logic              gb_cs_n,
    input  logic [DATA_W-1:0] pad_din,
    output logic [DATA_W-1:0] pad_dout,
    output logic [DATA_W-1:0] pad_oe,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_ram,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              mem_wr_stb,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_ram,
    output logic              rd_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        RD_DRIVE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic              rd_n_p0, rd_n_s, wr_n_p0, wr_n_s, cs_n_p0, cs_n_s;
    logic [ADDR_W-1:0] addr_p0, addr_s;
    logic              fill_p0, fill_p1;
    logic              rd_n_d, wr_n_d;
    logic [CNT_W-1:0]  wait_cnt;

    logic rd_fall, wr_fall, is_rom, is_ram, acc_ok, addr_ram;

    // Two-flop synchronizers plus strobe history; history reads as "low"
    // until the synchronizers have filled, so a strobe held low across
    // reset release never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_n_p0 <= 1'b1;
            rd_n_s  <= 1'b1;
            wr_n_p0 <= 1'b1;
            wr_n_s  <= 1'b1;
            cs_n_p0 <= 1'b1;
            cs_n_s  <= 1'b1;
            addr_p0 <= '0;
            addr_s  <= '0;
            fill_p0 <= 1'b0;
            fill_p1 <= 1'b0;
            rd_n_d  <= 1'b0;
            wr_n_d  <= 1'b0;
        end else begin
            rd_n_p0 <= gb_rd_n;
            rd_n_s  <= rd_n_p0;
            wr_n_p0 <= gb_wr_n;
            wr_n_s  <= wr_n_p0;
            cs_n_p0 <= gb_cs_n;
            cs_n_s  <= cs_n_p0;
            addr_p0 <= gb_addr;
            addr_s  <= addr_p0;
            fill_p0 <= 1'b1;
            fill_p1 <= fill_p0;
            rd_n_d  <= rd_n_s & fill_p1;
            wr_n_d  <= wr_n_s & fill_p1;
        end
    end

    assign rd_fall  = rd_n_d & ~rd_n_s;
    assign wr_fall  = wr_n_d & ~wr_n_s;
    assign addr_ram = (addr_s[ADDR_W-1 -: 3] == 3'b101);
    assign is_rom   = ~addr_s[ADDR_W-1];
    assign is_ram   = addr_ram & ~cs_n_s;
    assign acc_ok   = is_rom | is_ram;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decision; an abort (strobe released) outranks a late answer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rd_n_s && !wr_n_s)   state_nxt = IDLE;
                else if (rd_fall && acc_ok) state_nxt = RD_REQ;
                else if (wr_fall && acc_ok) state_nxt = WR_HOLD;
            end
            RD_REQ:   state_nxt = rd_n_s ? IDLE : RD_WAIT;
            RD_WAIT: begin
                if (rd_n_s)                                    state_nxt = IDLE;
                else if (mem_rd_valid)                         state_nxt = RD_DRIVE;
                else if (wait_cnt == CNT_W'(TIMEOUT - 1))      state_nxt = RD_DRIVE;
            end
            RD_DRIVE: if (rd_n_s || addr_s != mem_rd_addr) state_nxt = IDLE;
            WR_HOLD:  if (wr_n_s) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Address/data capture, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_addr <= '0;
            mem_rd_ram  <= 1'b0;
            pad_dout    <= '0;
            rd_timeout  <= 1'b0;
            wait_cnt    <= '0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_ram  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == RD_REQ) begin
                        mem_rd_addr <= addr_s;
                        mem_rd_ram  <= is_ram;
                    end
                    if (state_nxt == WR_HOLD) begin
                        mem_wr_addr <= addr_s;
                        mem_wr_data <= pad_din;
                        mem_wr_ram  <= addr_ram;
                    end
                end
                RD_REQ: wait_cnt <= '0;
                RD_WAIT: begin
                    if (state_nxt == RD_DRIVE) begin
                        if (mem_rd_valid) begin
                            pad_dout <= mem_rd_data;
                        end else begin
                            pad_dout   <= {DATA_W{1'b1}};
                            rd_timeout <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WR_HOLD: begin
                    // Stop sampling once the strobe rises so the write
                    // pulse carries the values seen while it was low.
                    if (!wr_n_s) begin
                        mem_wr_addr <= addr_s;
                        mem_wr_data <= pad_din;
                        mem_wr_ram  <= addr_ram;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and pad enable decoded straight from state so reset drops them at once.
    always_comb begin
        pad_oe     = {DATA_W{state == RD_DRIVE}};
        mem_rd_req = (state == RD_REQ);
        mem_wr_stb = (state == WR_HOLD) && wr_n_s;
    end

endmodule

// File: tb/tb_gb_bus_ctrl.sv
// Directed bench for gb_bus_ctrl with a queue-based scoreboard.
module tb_gb_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] gb_addr = 16'h0000;
    logic        gb_rd_n = 1'b1, gb_wr_n = 1'b1, gb_cs_n = 1'b1;
    logic [7:0]  pad_din = 8'h00;
    logic [7:0]  pad_dout, pad_oe;
    logic        mem_rd_req, mem_rd_ram, mem_rd_valid = 1'b0;
    logic [15:0] mem_rd_addr, mem_wr_addr;
    logic [7:0]  mem_rd_data = 8'h00, mem_wr_data;
    logic        mem_wr_stb, mem_wr_ram, rd_timeout;

    logic [16:0] rd_q[$];   // {ram, addr}
    logic [24:0] wr_q[$];   // {ram, addr, data}
    logic [7:0]  drv_q[$];  // pad_dout when pad_oe rises

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] prev_oe = 8'h00;

    gb_bus_ctrl #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .gb_addr(gb_addr), .gb_rd_n(gb_rd_n),
        .gb_wr_n(gb_wr_n), .gb_cs_n(gb_cs_n), .pad_din(pad_din),
        .pad_dout(pad_dout), .pad_oe(pad_oe), .mem_rd_req(mem_rd_req),
        .mem_rd_addr(mem_rd_addr), .mem_rd_ram(mem_rd_ram),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .mem_wr_stb(mem_wr_stb), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ram(mem_wr_ram),
        .rd_timeout(rd_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin
        logic [16:0] er;
        logic [24:0] ew;
        logic [7:0]  ed;
        if (!rst_n) begin
            prev_oe <= 8'h00;
        end else begin
            if (mem_rd_req && mem_wr_stb)
                unexpected("rd_wr_overlap", 32'(1));
            if (mem_rd_req) begin
                if (rd_q.size() == 0) unexpected("mem_rd_req", 32'({mem_rd_ram, mem_rd_addr}));
                else begin
                    er = rd_q.pop_front();
                    chk("rd_req", 32'({mem_rd_ram, mem_rd_addr}), 32'(er));
                end
            end
            if (mem_wr_stb) begin
                if (wr_q.size() == 0) unexpected("mem_wr_stb", 32'({mem_wr_ram, mem_wr_addr, mem_wr_data}));
                else begin
                    ew = wr_q.pop_front();
                    chk("wr_stb", 32'({mem_wr_ram, mem_wr_addr, mem_wr_data}), 32'(ew));
                end
            end
            if (pad_oe != 8'h00 && prev_oe == 8'h00) begin
                if (drv_q.size() == 0) unexpected("pad_oe", 32'(pad_oe));
                else begin
                    ed = drv_q.pop_front();
                    chk("drive_dout", 32'(pad_dout), 32'(ed));
                    chk("drive_oe", 32'(pad_oe), 32'hFF);
                end
            end
            prev_oe <= pad_oe;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_rd_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_seen", 32'(ok), 32'(1));
    endtask

    task automatic respond(input int dly, input logic [7:0] d);
        bit ok;
        wait_req(ok);
        if (ok) begin
            cyc(dly);
            mem_rd_data  = d;
            mem_rd_valid = 1'b1;
            cyc(1);
            mem_rd_valid = 1'b0;
        end
    endtask

    task automatic wait_stb();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_wr_stb) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stb_seen", 32'(ok), 32'(1));
    endtask

    task automatic pulse_valid(input logic [7:0] d);
        mem_rd_data  = d;
        mem_rd_valid = 1'b1;
        cyc(1);
        mem_rd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        // Reset state
        #1;
        chk("rst_pad_oe", 32'(pad_oe), 32'h0);
        chk("rst_pad_dout", 32'(pad_dout), 32'h0);
        chk("rst_rd_req", 32'(mem_rd_req), 32'h0);
        chk("rst_wr_stb", 32'(mem_wr_stb), 32'h0);
        chk("rst_rd_addr", 32'(mem_rd_addr), 32'h0);
        chk("rst_wr_addr", 32'(mem_wr_addr), 32'h0);
        chk("rst_wr_data", 32'(mem_wr_data), 32'h0);
        chk("rst_timeout", 32'(rd_timeout), 32'h0);
        cyc(3);
        rst_n = 1'b1;
        cyc(4);

        // ROM read, answer 3 cycles after the request
        gb_addr = 16'h0150;
        gb_rd_n = 1'b0;
        rd_q.push_back({1'b0, 16'h0150});
        drv_q.push_back(8'hC3);
        respond(3, 8'hC3);
        cyc(2);
        chk("rom_oe", 32'(pad_oe), 32'hFF);
        chk("rom_dout", 32'(pad_dout), 32'hC3);
        pulse_valid(8'h11);
        cyc(1);
        chk("rom_dout_hold", 32'(pad_dout), 32'hC3);
        gb_rd_n = 1'b1;
        cyc(2);
        chk("rom_oe_before_exit", 32'(pad_oe), 32'hFF);
        cyc(1);
        chk("rom_oe_after_exit", 32'(pad_oe), 32'h0);
        cyc(3);

        // RAM read timeout
        gb_addr = 16'hA000;
        gb_cs_n = 1'b0;
        gb_rd_n = 1'b0;
        rd_q.push_back({1'b1, 16'hA000});
        drv_q.push_back(8'hFF);
        wait_req(ok);
        cyc(15);
        chk("to_flag_early", 32'(rd_timeout), 32'h0);
        chk("to_oe_early", 32'(pad_oe), 32'h0);
        cyc(1);
        chk("to_flag", 32'(rd_timeout), 32'h1);
        chk("to_oe", 32'(pad_oe), 32'hFF);
        chk("to_dout", 32'(pad_dout), 32'hFF);
        gb_rd_n = 1'b1;
        gb_cs_n = 1'b1;
        cyc(4);

        // MBC write, 20 cycles low
        gb_addr = 16'h2000;
        pad_din = 8'h05;
        gb_wr_n = 1'b0;
        wr_q.push_back({1'b0, 16'h2000, 8'h05});
        cyc(10);
        chk("wr_oe", 32'(pad_oe), 32'h0);
        cyc(10);
        gb_wr_n = 1'b1;
        wait_stb();
        cyc(3);

        // RAM write, data changes while held
        gb_addr = 16'hA123;
        gb_cs_n = 1'b0;
        pad_din = 8'h00;
        gb_wr_n = 1'b0;
        wr_q.push_back({1'b1, 16'hA123, 8'h5A});
        cyc(5);
        pad_din = 8'h5A;
        cyc(5);
        gb_wr_n = 1'b1;
        wait_stb();
        gb_cs_n = 1'b1;
        cyc(3);

        // Aborted read with late answers
        gb_addr = 16'h0100;
        gb_rd_n = 1'b0;
        rd_q.push_back({1'b0, 16'h0100});
        cyc(3);
        gb_rd_n = 1'b1;
        cyc(2);
        pulse_valid(8'h99);
        cyc(3);
        pulse_valid(8'h98);
        cyc(3);
        chk("abort_oe", 32'(pad_oe), 32'h0);

        // Illegal simultaneous strobes
        gb_addr = 16'h0150;
        gb_rd_n = 1'b0;
        gb_wr_n = 1'b0;
        cyc(8);
        gb_rd_n = 1'b1;
        gb_wr_n = 1'b1;
        cyc(4);
        // Unmapped read, RAM read without chip select, unmapped write
        gb_addr = 16'hC000;
        gb_rd_n = 1'b0;
        cyc(8);
        gb_rd_n = 1'b1;
        cyc(4);
        gb_addr = 16'hA000;
        gb_rd_n = 1'b0;
        cyc(8);
        gb_rd_n = 1'b1;
        cyc(4);
        gb_addr = 16'hC000;
        gb_wr_n = 1'b0;
        cyc(8);
        gb_wr_n = 1'b1;
        cyc(4);
        chk("unmapped_oe", 32'(pad_oe), 32'h0);

        // Address change ends the drive
        gb_addr = 16'h0400;
        gb_rd_n = 1'b0;
        rd_q.push_back({1'b0, 16'h0400});
        drv_q.push_back(8'h3C);
        respond(1, 8'h3C);
        cyc(2);
        gb_addr = 16'h0401;
        cyc(3);
        chk("addr_exit_oe", 32'(pad_oe), 32'h0);
        gb_rd_n = 1'b1;
        cyc(4);

        // Reset in RD_DRIVE with strobe still low at release
        gb_addr = 16'h0200;
        gb_rd_n = 1'b0;
        rd_q.push_back({1'b0, 16'h0200});
        drv_q.push_back(8'h7E);
        respond(2, 8'h7E);
        cyc(2);
        chk("sticky_timeout", 32'(rd_timeout), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_drive_oe", 32'(pad_oe), 32'h0);
        chk("rst_drive_dout", 32'(pad_dout), 32'h0);
        chk("rst_drive_timeout", 32'(rd_timeout), 32'h0);
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        gb_rd_n = 1'b1;
        cyc(4);
        gb_addr = 16'h0300;
        gb_rd_n = 1'b0;
        rd_q.push_back({1'b0, 16'h0300});
        drv_q.push_back(8'hA5);
        respond(4, 8'hA5);
        cyc(2);
        gb_rd_n = 1'b1;
        cyc(5);

        chk("rd_q_left", 32'(rd_q.size()), 32'h0);
        chk("wr_q_left", 32'(wr_q.size()), 32'h0);
        chk("drv_q_left", 32'(drv_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
